clk_enable_debounce: RTL and testbench

CLK_ENABLE_DEBOUNCE -- requirements
Module: clk_enable_debounce

---
 rtl/clk_deb_pkg.sv | 20 ++
 rtl/debounce_ch.sv | 66 ++++++
 rtl/clk_enable_debounce.sv | 71 +++++++
 tb/tb_clk_enable_debounce.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_deb_pkg.sv
// Shared defaults and counter-sizing helper for clk_enable_debounce.
package clk_deb_pkg;

   localparam int unsigned CLK_HZ        = 100_000_000;
   localparam int unsigned PIX_DIV       = 4;
   localparam int unsigned SCAN_DIV      = 400_000;
   localparam int unsigned DB_CYCLES     = 1_000_000;
   localparam int unsigned REPEAT_CYCLES = 25_000_000;

   // Bits needed to hold 0..value-1; never less than one bit.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchronizer, stable-time counter, level and edge pulses.
// Build macro CLK_DEB_AUTOREPEAT_EN adds a repeat counter that re-fires pressPulse while held.
module debounce_ch
   import clk_deb_pkg::*;
#(
   parameter int unsigned DB_CYCLES     = clk_deb_pkg::DB_CYCLES
`ifdef CLK_DEB_AUTOREPEAT_EN
  ,parameter int unsigned REPEAT_CYCLES = clk_deb_pkg::REPEAT_CYCLES
`endif
)(
   input  logic clk,
   input  logic rst,
   input  logic btnRaw,
   output logic level,
   output logic pressPulse,
   output logic releasePulse
);

   localparam int unsigned      CW      = clog2(DB_CYCLES);
   localparam logic [CW-1:0]    DB_LAST = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] stableCnt;
   logic          flip;
   logic          repFire;

   assign flip = (sync2 != level) && (stableCnt == DB_LAST);

`ifdef CLK_DEB_AUTOREPEAT_EN
   localparam int unsigned   RW       = clog2(REPEAT_CYCLES);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] repCnt;

   // A release edge takes priority over a repeat that lands on the same cycle.
   assign repFire = level && !flip && (repCnt == REP_LAST);

   always_ff @(posedge clk) begin
      if (rst || !level || flip || repFire) repCnt <= '0;
      else                                  repCnt <= repCnt + RW'(1);
   end
`else
   assign repFire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1        <= 1'b0;
         sync2        <= 1'b0;
         stableCnt    <= '0;
         level        <= 1'b0;
         pressPulse   <= 1'b0;
         releasePulse <= 1'b0;
      end else begin
         sync1 <= btnRaw;
         sync2 <= sync1;
         if (sync2 == level || flip) stableCnt <= '0;
         else                        stableCnt <= stableCnt + CW'(1);
         if (flip) level <= ~level;
         pressPulse   <= (flip & ~level) | repFire;
         releasePulse <= flip & level;
      end
   end

endmodule

// File: rtl/clk_enable_debounce.sv
// Pixel/scan clock-enable strobes plus N_BTN independent button debouncers.
// Build macro CLK_DEB_AUTOREPEAT_EN enables btn_press auto-repeat while a button is held.
module clk_enable_debounce
   import clk_deb_pkg::*;
#(
   parameter int unsigned CLK_HZ        = clk_deb_pkg::CLK_HZ,
   parameter int unsigned PIX_DIV       = clk_deb_pkg::PIX_DIV,
   parameter int unsigned SCAN_DIV      = clk_deb_pkg::SCAN_DIV,
   parameter int unsigned N_BTN         = 4,
   parameter int unsigned DB_CYCLES     = clk_deb_pkg::DB_CYCLES,
   parameter int unsigned REPEAT_CYCLES = clk_deb_pkg::REPEAT_CYCLES
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic             pix_en,
   output logic             scan_tick,
   output logic [1:0]       scan_idx,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   localparam int unsigned   PW        = clog2(PIX_DIV);
   localparam int unsigned   SW        = clog2(SCAN_DIV);
   localparam logic [PW-1:0] PIX_LAST  = PW'(PIX_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   if (CLK_HZ == 0 || PIX_DIV < 2 || SCAN_DIV < 2 || N_BTN < 1 ||
       DB_CYCLES < 2 || REPEAT_CYCLES < 1) begin : gBadParams
      $error("clk_enable_debounce: parameter out of legal range");
   end

   logic [PW-1:0] pixCnt;
   logic [SW-1:0] scanCnt;

   // Strobes are registered from the terminal count, so the first one
   // appears on the DIV-th cycle after reset is released.
   always_ff @(posedge clk) begin
      if (rst) begin
         pixCnt    <= '0;
         scanCnt   <= '0;
         pix_en    <= 1'b0;
         scan_tick <= 1'b0;
         scan_idx  <= '0;
      end else begin
         pix_en    <= (pixCnt == PIX_LAST);
         pixCnt    <= (pixCnt == PIX_LAST) ? '0 : pixCnt + PW'(1);
         scan_tick <= (scanCnt == SCAN_LAST);
         scanCnt   <= (scanCnt == SCAN_LAST) ? '0 : scanCnt + SW'(1);
         if (scan_tick) scan_idx <= scan_idx + 2'd1;
      end
   end

   for (genvar g = 0; g < N_BTN; g++) begin : gBtn
      debounce_ch #(
         .DB_CYCLES     (DB_CYCLES)
`ifdef CLK_DEB_AUTOREPEAT_EN
        ,.REPEAT_CYCLES (REPEAT_CYCLES)
`endif
      ) uCh (
         .clk          (clk),
         .rst          (rst),
         .btnRaw       (btn_raw[g]),
         .level        (btn_level[g]),
         .pressPulse   (btn_press[g]),
         .releasePulse (btn_release[g])
      );
   end

endmodule

// File: tb/tb_clk_enable_debounce.sv
// Scoreboard bench for clk_enable_debounce; honours CLK_DEB_AUTOREPEAT_EN if defined.
`timescale 1ns/1ps
module tb_clk_enable_debounce;

   localparam int unsigned PIX  = 4;
   localparam int unsigned SCAN = 10;
   localparam int unsigned DB   = 8;
   localparam int unsigned NB   = 2;
   localparam int unsigned REP  = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_raw;
   logic          pix_en;
   logic          scan_tick;
   logic [1:0]    scan_idx;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;

   always #5 clk = ~clk;

   clk_enable_debounce #(
      .CLK_HZ        (100_000_000),
      .PIX_DIV       (PIX),
      .SCAN_DIV      (SCAN),
      .N_BTN         (NB),
      .DB_CYCLES     (DB),
      .REPEAT_CYCLES (REP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .pix_en      (pix_en),
      .scan_tick   (scan_tick),
      .scan_idx    (scan_idx),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   typedef struct {
      int unsigned   cyc;
      logic [NB-1:0] press;
      logic [NB-1:0] rel;
      logic [NB-1:0] lvl;
   } btnEv_t;

   typedef struct {
      int unsigned cyc;
      logic [1:0]  idx;
   } scanEv_t;

   int unsigned total = 0;
   int unsigned bad   = 0;

   int unsigned pixQ[$];
   scanEv_t     scanQ[$];
   btnEv_t      btnQ[$];

   // Reference model: edges counted from reset release, raw history per edge.
   int unsigned   mEdge;
   logic [NB-1:0] rawHist[$];
   logic [NB-1:0] mLevel;
   int unsigned   mOnEdge[NB];

   // Monitor-side cycle count.
   int unsigned mcyc = 0;
   logic        rstAtEdge = 1'b0;
   bit          started = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", nm, act, exp, mcyc, $time);
      end
   endtask

   function automatic logic rawAt(input int k, input int unsigned ch);
      logic [NB-1:0] v;
      if (k < 1) return 1'b0;
      v = rawHist[k-1];
      return v[ch];
   endfunction

   // Level flips at an edge once the synchronised input (raw two edges back)
   // has disagreed with the level for DB consecutive edges.
   task automatic modelEdge(input logic r, input logic [NB-1:0] raw);
      btnEv_t  ev;
      scanEv_t se;
      bit      flips;
      if (r) begin
         mEdge  = 0;
         rawHist.delete();
         mLevel = '0;
         return;
      end
      mEdge++;
      rawHist.push_back(raw);
      if (mEdge % PIX == 0) pixQ.push_back(mEdge);
      if (mEdge % SCAN == 0) begin
         se.cyc = mEdge;
         se.idx = 2'((mEdge / SCAN - 1) % 4);
         scanQ.push_back(se);
      end
      ev.cyc   = mEdge;
      ev.press = '0;
      ev.rel   = '0;
      for (int unsigned ch = 0; ch < NB; ch++) begin
         flips = 1'b1;
         for (int i = 0; i < int'(DB); i++)
            if (rawAt(int'(mEdge) - 2 - i, ch) == mLevel[ch]) flips = 1'b0;
         if (flips) begin
            mLevel[ch] = ~mLevel[ch];
            if (mLevel[ch]) begin
               ev.press[ch] = 1'b1;
               mOnEdge[ch]  = mEdge;
            end else begin
               ev.rel[ch] = 1'b1;
            end
         end
`ifdef CLK_DEB_AUTOREPEAT_EN
         else if (mLevel[ch] && ((mEdge - mOnEdge[ch]) % REP == 0)) ev.press[ch] = 1'b1;
`endif
      end
      ev.lvl = mLevel;
      if ((ev.press | ev.rel) != '0) btnQ.push_back(ev);
   endtask

   task automatic step(input logic r, input logic [NB-1:0] raw);
      rst     = r;
      btn_raw = raw;
      modelEdge(r, raw);
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      started   <= 1'b1;
      rstAtEdge <= rst;
      mcyc      <= rst ? 0 : mcyc + 1;
   end

   always @(negedge clk) begin
      btnEv_t  be;
      scanEv_t se;
      int unsigned pe;
      if (started) begin
         if (rstAtEdge) begin
            chk("reset_outputs", {pix_en, scan_tick, scan_idx, btn_level, btn_press, btn_release}, '0);
         end else begin
            if (pixQ.size() > 0 && pixQ[0] <= mcyc) begin
               pe = pixQ.pop_front();
               chk("pix_en_at_cycle", pix_en, 1'b1);
               chk("pix_en_cycle", mcyc, pe);
            end else if (pix_en) begin
               chk("pix_en_unexpected", pix_en, 1'b0);
            end

            if (scanQ.size() > 0 && scanQ[0].cyc <= mcyc) begin
               se = scanQ.pop_front();
               chk("scan_tick_at_cycle", scan_tick, 1'b1);
               chk("scan_idx_at_tick", scan_idx, se.idx);
            end else if (scan_tick) begin
               chk("scan_tick_unexpected", scan_tick, 1'b0);
            end

            if (btnQ.size() > 0 && btnQ[0].cyc <= mcyc) begin
               be = btnQ.pop_front();
               chk("btn_press", btn_press, be.press);
               chk("btn_release", btn_release, be.rel);
               chk("btn_level", btn_level, be.lvl);
            end else if ((btn_press | btn_release) != '0) begin
               chk("btn_pulse_unexpected", {btn_press, btn_release}, '0);
            end
         end
      end
   end

   initial begin
      logic [NB-1:0] cur;
      int unsigned   hold;
      rst     = 1'b1;
      btn_raw = '0;
      repeat (3) step(1'b1, '0);

      repeat (40) step(1'b0, '0);                 // strobes only

      repeat (20) step(1'b0, 2'b01);              // clean press
      repeat (20) step(1'b0, 2'b00);

      for (int k = 0; k < 10; k++)                // bounce, then settle high
         repeat (3) step(1'b0, (k % 2 == 0) ? 2'b01 : 2'b00);
      repeat (20) step(1'b0, 2'b01);
      repeat (20) step(1'b0, 2'b00);

      repeat (20) step(1'b0, 2'b11);              // simultaneous channels
      repeat (20) step(1'b0, 2'b00);

      repeat (5)  step(1'b0, 2'b01);              // reset mid-debounce
      repeat (3)  step(1'b1, 2'b01);
      repeat (20) step(1'b0, 2'b01);
      repeat (20) step(1'b0, 2'b00);

      repeat (75) step(1'b0, 2'b10);              // long hold
      repeat (20) step(1'b0, 2'b00);

      cur = '0;
      for (int k = 0; k < 80; k++) begin
         cur  = cur ^ NB'($urandom_range(1, 3));
         hold = $urandom_range(1, 14);
         repeat (hold) step(1'b0, cur);
      end
      repeat (30) step(1'b0, '0);

      @(negedge clk);
      #1;
      chk("pix_queue_drained", pixQ.size(), 0);
      chk("scan_queue_drained", scanQ.size(), 0);
      chk("btn_queue_drained", btnQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
